apb_pmod_gpio: RTL and testbench

APB-controlled GPIO block for student subsystems. It is a parametrised successor to the fixed two-port, 4-bit pmod wiring. It serves `N_PMOD` pmod ports of `PMOD_W` bits each and provides per-bit output data and output enable, synchronised inputs, and edge-detect interrupts with per-bit mask and write-1-to-clear status. It sits behind the subsystem APB slave port and drives the pmod pad signals and the subsystem IRQ line.

---
 rtl/apb_pmod_gpio.sv | 185 ++++++++++++++++++
 tb/tb_apb_pmod_gpio.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pmod_gpio.sv
// APB-controlled GPIO for N_PMOD pmod ports: per-bit output data and output
// enable, two-flop synchronised inputs, and edge-detect interrupts with a
// per-bit mask and write-1-to-clear status.
module apb_pmod_gpio #(
  parameter int APB_AW = 32,
  parameter int APB_DW = 32,
  parameter int N_PMOD = 2,
  parameter int PMOD_W = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_int,
  input  logic [APB_AW-1:0]        PADDR,
  input  logic                     PENABLE,
  input  logic                     PSEL,
  input  logic [APB_DW-1:0]        PWDATA,
  input  logic                     PWRITE,
  output logic [APB_DW-1:0]        PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic                     irq,
  input  logic                     irq_en,
  input  logic [7:0]               ss_ctrl,
  input  logic [N_PMOD*PMOD_W-1:0] pmod_gpi,
  output logic [N_PMOD*PMOD_W-1:0] pmod_gpo,
  output logic [N_PMOD*PMOD_W-1:0] pmod_gpio_oe
);

  localparam int TW = N_PMOD * PMOD_W;

  logic [TW-1:0] out_q, out_d;
  logic [TW-1:0] oe_q, oe_d;
  logic [TW-1:0] mask_q, mask_d;
  logic [TW-1:0] rise_q, rise_d;
  logic [TW-1:0] fall_q, fall_d;
  logic [TW-1:0] status_q, status_d;
  logic [TW-1:0] sync1_q, sync2_q, prev_q;
  logic          irq_q;

  logic [7:0]        addr;
  logic              is_global;
  logic [2:0]        port_idx;
  logic [1:0]        reg_sel;
  logic              err;
  logic              wr_en;
  logic              rd_en;
  logic              enable;
  logic [TW-1:0]     w1c;
  logic [TW-1:0]     set_bits;
  logic [APB_DW-1:0] rdata;
  logic              unused_bits;

  assign addr      = PADDR[7:0];
  assign is_global = addr[7];
  assign port_idx  = addr[6:4];
  assign reg_sel   = addr[3:2];
  assign enable    = ss_ctrl[0];

  // Only the low address byte, ss_ctrl[0] and the low data bits carry meaning.
  assign unused_bits = ^{PADDR, ss_ctrl, PWDATA};

  // Classify the access: misaligned, unmapped, absent port or write to IN.
  always_comb begin
    err = 1'b0;
    if (addr[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (is_global) begin
      if (addr[6:4] != 3'd0) err = 1'b1;
    end else begin
      if (reg_sel == 2'd3)                 err = 1'b1;
      else if (int'(port_idx) >= N_PMOD)   err = 1'b1;
      else if (reg_sel == 2'd2 && PWRITE)  err = 1'b1;
    end
  end

  assign wr_en   = PSEL & PENABLE & PWRITE & ~err;
  assign rd_en   = PSEL & ~PWRITE & ~err;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & err;

  // Edge events only count while the block is enabled.
  assign set_bits = ((sync2_q & ~prev_q & rise_q) |
                     (~sync2_q & prev_q & fall_q)) & {TW{enable}};

  // Register next-state: APB writes, and status where a new edge beats W1C.
  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    mask_d = mask_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (wr_en) begin
      if (is_global) begin
        case (reg_sel)
          2'd0: mask_d = PWDATA[TW-1:0];
          2'd1: rise_d = PWDATA[TW-1:0];
          2'd2: fall_d = PWDATA[TW-1:0];
          default: w1c = PWDATA[TW-1:0];
        endcase
      end else begin
        for (int p = 0; p < N_PMOD; p++) begin
          if (int'(port_idx) == p) begin
            case (reg_sel)
              2'd0: out_d[p*PMOD_W +: PMOD_W] = PWDATA[PMOD_W-1:0];
              2'd1: oe_d[p*PMOD_W +: PMOD_W]  = PWDATA[PMOD_W-1:0];
              default: ;
            endcase
          end
        end
      end
    end
    status_d = (status_q & ~w1c) | set_bits;
  end

  // Read mux; quiet zero unless a valid read is selected.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (is_global) begin
        case (reg_sel)
          2'd0: rdata[TW-1:0] = mask_q;
          2'd1: rdata[TW-1:0] = rise_q;
          2'd2: rdata[TW-1:0] = fall_q;
          default: rdata[TW-1:0] = status_q;
        endcase
      end else begin
        for (int p = 0; p < N_PMOD; p++) begin
          if (int'(port_idx) == p) begin
            case (reg_sel)
              2'd0: rdata[PMOD_W-1:0] = out_q[p*PMOD_W +: PMOD_W];
              2'd1: rdata[PMOD_W-1:0] = oe_q[p*PMOD_W +: PMOD_W];
              2'd2: rdata[PMOD_W-1:0] = sync2_q[p*PMOD_W +: PMOD_W];
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign PRDATA = rdata;

  // Two-flop synchroniser followed by the previous-value flop for edge detect.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pmod_gpi;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      out_q    <= '0;
      oe_q     <= '0;
      mask_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
    end else begin
      out_q    <= out_d;
      oe_q     <= oe_d;
      mask_q   <= mask_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
    end
  end

  // Registered interrupt so the IRQ line is glitch-free.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) irq_q <= 1'b0;
    else            irq_q <= irq_en & enable & (|(status_q & mask_q));
  end

  assign irq          = irq_q;
  assign pmod_gpo     = out_q & {TW{enable}};
  assign pmod_gpio_oe = oe_q & {TW{enable}};

endmodule

// File: tb/tb_apb_pmod_gpio.sv
// Directed bench for apb_pmod_gpio with the default two 4-bit ports.
module tb_apb_pmod_gpio;

  logic        clk_in;
  logic        reset_int;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        irq;
  logic        irq_en;
  logic [7:0]  ss_ctrl;
  logic [7:0]  pmod_gpi;
  logic [7:0]  pmod_gpo;
  logic [7:0]  pmod_gpio_oe;

  int checks = 0;
  int errors = 0;

  apb_pmod_gpio dut (
    .clk_in       (clk_in),
    .reset_int    (reset_int),
    .PADDR        (PADDR),
    .PENABLE      (PENABLE),
    .PSEL         (PSEL),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .irq          (irq),
    .irq_en       (irq_en),
    .ss_ctrl      (ss_ctrl),
    .pmod_gpi     (pmod_gpi),
    .pmod_gpo     (pmod_gpo),
    .pmod_gpio_oe (pmod_gpio_oe)
  );

  // Free-running clock, 10 time units per period.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One APB transfer; PRDATA/PSLVERR are sampled mid access phase.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic slverr);
    @(negedge clk_in);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = {24'd0, addr};
    PWDATA  = wdata;
    @(negedge clk_in);
    PENABLE = 1'b1;
    #1;
    rdata  = PRDATA;
    slverr = PSLVERR;
    @(posedge clk_in);
    #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic regWrite(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        se;
    applyStimulus(1'b1, addr, data, rd, se);
    checkOutput($sformatf("wr_err_%0h", addr), {31'd0, se}, 32'd0);
  endtask

  task automatic regRead(input logic [7:0] addr, input logic [31:0] expected,
                         input string tag);
    logic [31:0] rd;
    logic        se;
    applyStimulus(1'b0, addr, 32'd0, rd, se);
    checkOutput({tag, "_err"}, {31'd0, se}, 32'd0);
    checkOutput(tag, rd, expected);
  endtask

  task automatic errAccess(input logic wr, input logic [7:0] addr,
                           input logic [31:0] data, input string tag);
    logic [31:0] rd;
    logic        se;
    applyStimulus(wr, addr, data, rd, se);
    checkOutput({tag, "_slverr"}, {31'd0, se}, 32'd1);
    checkOutput({tag, "_rdata"}, rd, 32'd0);
  endtask

  initial begin
    reset_int = 1'b0;
    PADDR     = '0;
    PENABLE   = 1'b0;
    PSEL      = 1'b0;
    PWDATA    = '0;
    PWRITE    = 1'b0;
    irq_en    = 1'b0;
    ss_ctrl   = 8'h01;
    pmod_gpi  = 8'h00;
    repeat (3) @(negedge clk_in);
    checkOutput("rst_gpo", {24'd0, pmod_gpo}, 32'h0);
    checkOutput("rst_oe", {24'd0, pmod_gpio_oe}, 32'h0);
    checkOutput("rst_irq", {31'd0, irq}, 32'h0);
    checkOutput("rst_pready", {31'd0, PREADY}, 32'h1);
    checkOutput("rst_pslverr", {31'd0, PSLVERR}, 32'h0);
    checkOutput("rst_prdata", PRDATA, 32'h0);
    reset_int = 1'b1;

    $display("[TB] reset values of every mapped register");
    regRead(8'h00, 32'h0, "out0");
    regRead(8'h04, 32'h0, "oe0");
    regRead(8'h08, 32'h0, "in0");
    regRead(8'h10, 32'h0, "out1");
    regRead(8'h14, 32'h0, "oe1");
    regRead(8'h18, 32'h0, "in1");
    regRead(8'h80, 32'h0, "mask");
    regRead(8'h84, 32'h0, "rise");
    regRead(8'h88, 32'h0, "fall");
    regRead(8'h8C, 32'h0, "status");

    $display("[TB] pad outputs and block enable");
    regWrite(8'h00, 32'hA);
    regWrite(8'h04, 32'hF);
    checkOutput("gpo_on", {24'd0, pmod_gpo}, 32'h0A);
    checkOutput("oe_on", {24'd0, pmod_gpio_oe}, 32'h0F);
    ss_ctrl = 8'h00;
    #1;
    checkOutput("gpo_off", {24'd0, pmod_gpo}, 32'h00);
    checkOutput("oe_off", {24'd0, pmod_gpio_oe}, 32'h00);
    ss_ctrl = 8'h01;
    #1;
    checkOutput("gpo_back", {24'd0, pmod_gpo}, 32'h0A);
    checkOutput("oe_back", {24'd0, pmod_gpio_oe}, 32'h0F);
    regRead(8'h00, 32'hA, "out0_rb");

    $display("[TB] rising edge interrupt latency and W1C");
    regWrite(8'h84, 32'h10);
    regWrite(8'h80, 32'h10);
    irq_en = 1'b1;
    @(negedge clk_in);
    pmod_gpi[4] = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("irq_not_yet", {31'd0, irq}, 32'h0);
    @(posedge clk_in);
    #1;
    checkOutput("irq_rise", {31'd0, irq}, 32'h1);
    regRead(8'h18, 32'h1, "in1_sync");
    regRead(8'h8C, 32'h10, "status_rise");
    regWrite(8'h8C, 32'h10);
    checkOutput("irq_hold_after_w1c", {31'd0, irq}, 32'h1);
    @(posedge clk_in);
    #1;
    checkOutput("irq_drop_after_w1c", {31'd0, irq}, 32'h0);
    regRead(8'h8C, 32'h0, "status_cleared");

    $display("[TB] status sets with mask off, then mask raises irq");
    regWrite(8'h80, 32'h00);
    @(negedge clk_in);
    pmod_gpi[4] = 1'b0;
    repeat (5) @(posedge clk_in);
    regRead(8'h8C, 32'h0, "status_fall_disabled");
    @(negedge clk_in);
    pmod_gpi[4] = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    checkOutput("irq_masked", {31'd0, irq}, 32'h0);
    regRead(8'h8C, 32'h10, "status_masked");
    regWrite(8'h80, 32'h10);
    checkOutput("irq_mask_same_edge", {31'd0, irq}, 32'h0);
    @(posedge clk_in);
    #1;
    checkOutput("irq_mask_next", {31'd0, irq}, 32'h1);
    regWrite(8'h8C, 32'h10);
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("irq_cleared2", {31'd0, irq}, 32'h0);

    $display("[TB] set beats W1C on the same edge");
    @(negedge clk_in);
    pmod_gpi[0] = 1'b1;
    repeat (5) @(posedge clk_in);
    regWrite(8'h88, 32'h01);
    @(negedge clk_in);
    pmod_gpi[0] = 1'b0;
    repeat (5) @(posedge clk_in);
    regRead(8'h8C, 32'h01, "status_fall");
    @(negedge clk_in);
    pmod_gpi[0] = 1'b1;
    repeat (5) @(posedge clk_in);
    regRead(8'h8C, 32'h01, "status_pending");
    @(negedge clk_in);
    pmod_gpi[0] = 1'b0;
    regWrite(8'h8C, 32'h01);
    regRead(8'h8C, 32'h01, "status_set_wins");
    regWrite(8'h8C, 32'h01);
    regRead(8'h8C, 32'h00, "status_w1c_plain");

    $display("[TB] error responses");
    errAccess(1'b0, 8'h0C, 32'h0, "rd_0c");
    errAccess(1'b1, 8'h0C, 32'h5, "wr_0c");
    errAccess(1'b0, 8'h20, 32'h0, "rd_20");
    errAccess(1'b1, 8'h20, 32'hF, "wr_20");
    errAccess(1'b1, 8'h02, 32'h5, "wr_02");
    errAccess(1'b0, 8'h02, 32'h0, "rd_02");
    errAccess(1'b1, 8'h08, 32'hF, "wr_in0");
    errAccess(1'b0, 8'h90, 32'h0, "rd_90");
    regRead(8'h00, 32'hA, "out0_after_err");
    regRead(8'h04, 32'hF, "oe0_after_err");
    regRead(8'h08, 32'h0, "in0_after_err");
    regRead(8'h80, 32'h10, "mask_after_err");
    checkOutput("gpo_after_err", {24'd0, pmod_gpo}, 32'h0A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
